sdram_arbiter: RTL and testbench

- Shares the single-port sdram controller between three sources: the CPU memory port of main (ramRd/ramWr/ramA/ramD), the CPU refresh strobe, and a bulk loader port that streams ROM/snapshot bytes from the SD card path.
- Sits between main and the sdram controller; drives the controller's refresh/read/write/portD/portA and demultiplexes portQ.
- Grants one operation at a time with fixed priority and a fixed-length service window. CPU accesses have a bounded, deterministic latency.

---
 rtl/sdram_arbiter_if.sv | 57 +++++
 rtl/sdram_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: CPU memory port, bulk loader port and sdram controller
// port of sdram_arbiter, bundled so the arbiter and its neighbours share one
// definition. Optional output cpuWait exists only when SDRAM_ARBITER_WAIT_EN
// is defined.
interface sdram_arbiter_if #(
  parameter int AW = 18
);
  // CPU memory port
  logic          cpuRd;
  logic          cpuWr;
  logic          cpuRf;
  logic [AW-1:0] cpuA;
  logic [7:0]    cpuD;
  logic [7:0]    cpuQ;
`ifdef SDRAM_ARBITER_WAIT_EN
  logic          cpuWait;
`endif
  // Bulk loader port
  logic          ldrReq;
  logic          ldrWe;
  logic [AW-1:0] ldrA;
  logic [7:0]    ldrD;
  logic [7:0]    ldrQ;
  logic          ldrAck;
  logic          ldrBusy;
  // sdram controller port
  logic          sdrRf;
  logic          sdrRd;
  logic          sdrWr;
  logic [15:0]   sdrD;
  logic [23:0]   sdrA;
  logic [15:0]   sdrQ;

  // Arbiter side
  modport slave (
    input  cpuRd, cpuWr, cpuRf, cpuA, cpuD,
    input  ldrReq, ldrWe, ldrA, ldrD,
    input  sdrQ,
    output cpuQ, ldrQ, ldrAck, ldrBusy,
    output sdrRf, sdrRd, sdrWr, sdrD, sdrA
`ifdef SDRAM_ARBITER_WAIT_EN
    , output cpuWait
`endif
  );

  // Requester / controller-model side
  modport master (
    output cpuRd, cpuWr, cpuRf, cpuA, cpuD,
    output ldrReq, ldrWe, ldrA, ldrD,
    output sdrQ,
    input  cpuQ, ldrQ, ldrAck, ldrBusy,
    input  sdrRf, sdrRd, sdrWr, sdrD, sdrA
`ifdef SDRAM_ARBITER_WAIT_EN
    , input cpuWait
`endif
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one sdram controller between the CPU memory port,
// the CPU refresh strobe and the bulk loader. One operation at a time, fixed
// priority CPU > refresh > loader, fixed-length service windows.
// Optional feature macro: SDRAM_ARBITER_WAIT_EN adds output cpuWait.
module sdram_arbiter #(
  parameter int AW    = 18,
  parameter int OPLEN = 8,
  parameter int RFLEN = 8
) (
  input  logic            clock,
  input  logic            reset,
  sdram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CPU, RFSH, LDR} state_t;

  localparam int LEN_MAX = (OPLEN > RFLEN) ? OPLEN : RFLEN;
  localparam int CW      = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam logic [CW-1:0] OP_LAST = CW'(OPLEN - 1);
  localparam logic [CW-1:0] RF_LAST = CW'(RFLEN - 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            start_cpu, start_rf, start_ld, win_last;

  logic            cpu_rd_q, cpu_wr_q, cpu_rf_q;
  logic            pend_rd, pend_wr, pend_rf, pend_ld;
  logic [AW-1:0]   rd_addr, wr_addr, ld_addr;
  logic [7:0]      wr_data, ld_data;
  logic            ld_we, serve_wr;

  logic [7:0]      cpu_q, ldr_q;
  logic            ldr_ack;
  logic            sdr_rf, sdr_rd, sdr_wr;
  logic [15:0]     sdr_d;
  logic [23:0]     sdr_a;

  logic            rd_edge, wr_edge, rf_edge;
  logic            clr_rd, clr_wr, clr_rf, clr_ld;

  assign rd_edge = bus.cpuRd & ~cpu_rd_q;
  assign wr_edge = bus.cpuWr & ~cpu_wr_q;
  assign rf_edge = bus.cpuRf & ~cpu_rf_q;

  // A window retires its own pending flag on its last count only.
  assign clr_rd = win_last && (state == CPU) && !serve_wr;
  assign clr_wr = win_last && (state == CPU) &&  serve_wr;
  assign clr_rf = win_last && (state == RFSH);
  assign clr_ld = win_last && (state == LDR);

  // Arbitration from IDLE and window counting.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned; otherwise a latch is inferred.
    state_d   = state;
    cnt_d     = cnt;
    start_cpu = 1'b0;
    start_rf  = 1'b0;
    start_ld  = 1'b0;
    win_last  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (pend_rd || pend_wr) begin
          state_d   = CPU;
          start_cpu = 1'b1;
        end else if (pend_rf) begin
          state_d  = RFSH;
          start_rf = 1'b1;
        end else if (pend_ld) begin
          state_d  = LDR;
          start_ld = 1'b1;
        end
      end
      CPU, LDR: begin
        if (cnt == OP_LAST) begin
          state_d  = IDLE;
          win_last = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RFSH: begin
        if (cnt == RF_LAST) begin
          state_d  = IDLE;
          win_last = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and window counter.
  always_ff @(posedge clock) begin
    // NOTE: flops use <= so every register sees pre-edge values; = would make results depend on block order.
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Request capture, strobes, address/data drive and read-data return.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cpu_rd_q <= 1'b0;
      cpu_wr_q <= 1'b0;
      cpu_rf_q <= 1'b0;
      pend_rd  <= 1'b0;
      pend_wr  <= 1'b0;
      pend_rf  <= 1'b0;
      pend_ld  <= 1'b0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      ld_addr  <= '0;
      wr_data  <= '0;
      ld_data  <= '0;
      ld_we    <= 1'b0;
      serve_wr <= 1'b0;
      cpu_q    <= '0;
      ldr_q    <= '0;
      ldr_ack  <= 1'b0;
      sdr_rf   <= 1'b0;
      sdr_rd   <= 1'b0;
      sdr_wr   <= 1'b0;
      sdr_d    <= '0;
      sdr_a    <= '0;
    end else begin
      cpu_rd_q <= bus.cpuRd;
      cpu_wr_q <= bus.cpuWr;
      cpu_rf_q <= bus.cpuRf;

      // First request wins; a flag retiring this clock may be re-armed.
      if (rd_edge && (!pend_rd || clr_rd)) begin
        pend_rd <= 1'b1;
        rd_addr <= bus.cpuA;
      end else if (clr_rd) begin
        pend_rd <= 1'b0;
      end

      if (wr_edge && (!pend_wr || clr_wr)) begin
        pend_wr <= 1'b1;
        wr_addr <= bus.cpuA;
        wr_data <= bus.cpuD;
      end else if (clr_wr) begin
        pend_wr <= 1'b0;
      end

      if (rf_edge && (!pend_rf || clr_rf)) begin
        pend_rf <= 1'b1;
      end else if (clr_rf) begin
        pend_rf <= 1'b0;
      end

      // pend_ld doubles as ldrBusy, so requests are ignored until the ack clock.
      if (bus.ldrReq && !pend_ld) begin
        pend_ld <= 1'b1;
        ld_we   <= bus.ldrWe;
        ld_addr <= bus.ldrA;
        ld_data <= bus.ldrD;
      end else if (clr_ld) begin
        pend_ld <= 1'b0;
      end

      if (start_cpu) begin
        serve_wr <= pend_wr;
      end

      // Only one start_* can be high, so strobes are exclusive by construction.
      sdr_rf <= start_rf;
      sdr_rd <= (start_cpu && !pend_wr) || (start_ld && !ld_we);
      sdr_wr <= (start_cpu &&  pend_wr) || (start_ld &&  ld_we);

      if (start_cpu) begin
        sdr_a <= 24'(pend_wr ? wr_addr : rd_addr);
        sdr_d <= {2{wr_data}};
      end else if (start_ld) begin
        sdr_a <= 24'(ld_addr);
        sdr_d <= {2{ld_data}};
      end

      ldr_ack <= clr_ld;
      if (clr_rd) begin
        cpu_q <= bus.sdrQ[7:0];
      end
      if (clr_ld && !ld_we) begin
        ldr_q <= bus.sdrQ[7:0];
      end
    end
  end

  assign bus.cpuQ    = cpu_q;
  assign bus.ldrQ    = ldr_q;
  assign bus.ldrAck  = ldr_ack;
  assign bus.ldrBusy = pend_ld;
  assign bus.sdrRf   = sdr_rf;
  assign bus.sdrRd   = sdr_rd;
  assign bus.sdrWr   = sdr_wr;
  assign bus.sdrD    = sdr_d;
  assign bus.sdrA    = sdr_a;

`ifdef SDRAM_ARBITER_WAIT_EN
  assign bus.cpuWait = pend_rd | pend_wr | (state == CPU);
`endif

  // The controller returns 16 bits; only the low byte carries data.
  logic unused_sdr_q_hi;
  assign unused_sdr_q_hi = ^bus.sdrQ[15:8];

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: random and directed stimulus for sdram_arbiter, checked
// every clock against a transaction-level model (pending request sets, a
// busy-until window and priority selection).
module tb_sdram_arbiter;
  localparam int AW    = 18;
  localparam int OPLEN = 8;
  localparam int RFLEN = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  sdram_arbiter_if #(.AW(AW)) bus ();

  sdram_arbiter #(.AW(AW), .OPLEN(OPLEN), .RFLEN(RFLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum logic [2:0] {OP_NONE, OP_CRD, OP_CWR, OP_RF, OP_LRD, OP_LWR} op_e;

  typedef struct packed {
    logic          rst;
    logic          rd, wr, rf;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic          lreq, lwe;
    logic [AW-1:0] la;
    logic [7:0]    ld;
    logic [15:0]   q;
  } in_t;

  in_t p = '0;   // inputs the DUT samples at the coming posedge

  logic          m_prd, m_pwr, m_prf, m_pld, m_lwe;
  logic [AW-1:0] m_ard, m_awr, m_ald;
  logic [7:0]    m_dwr, m_dld, m_cpuq, m_ldrq;
  logic          m_ack;
  logic          prev_rd, prev_wr, prev_rf;
  logic          win_on = 1'b0;
  int            win_end;
  op_e           win_op;
  logic [AW-1:0] win_a;
  logic [7:0]    win_d;

  always @(negedge clock) begin
    op_e  g;
    logic ld_acc;
    cyc++;
    g = OP_NONE;
    if (!p.rst) begin
      m_prd = 0; m_pwr = 0; m_prf = 0; m_pld = 0; m_ack = 0;
      m_cpuq = '0; m_ldrq = '0; win_on = 0;
      prev_rd = 0; prev_wr = 0; prev_rf = 0;
    end else begin
      // Grant is decided on what was pending before this edge.
      if (!win_on) begin
        if (m_pwr) begin g = OP_CWR; win_a = m_awr; win_d = m_dwr; end
        else if (m_prd) begin g = OP_CRD; win_a = m_ard; end
        else if (m_prf) g = OP_RF;
        else if (m_pld) begin g = m_lwe ? OP_LWR : OP_LRD; win_a = m_ald; win_d = m_dld; end
      end
      m_ack  = 0;
      ld_acc = p.lreq && !m_pld;
      if (win_on && cyc == win_end) begin
        win_on = 0;
        case (win_op)
          OP_CRD: begin m_prd = 0; m_cpuq = p.q[7:0]; end
          OP_CWR: m_pwr = 0;
          OP_RF:  m_prf = 0;
          OP_LRD: begin m_pld = 0; m_ldrq = p.q[7:0]; m_ack = 1; end
          OP_LWR: begin m_pld = 0; m_ack = 1; end
          default: ;
        endcase
      end
      if (p.rd && !prev_rd && !m_prd) begin m_prd = 1; m_ard = p.a; end
      if (p.wr && !prev_wr && !m_pwr) begin m_pwr = 1; m_awr = p.a; m_dwr = p.d; end
      if (p.rf && !prev_rf && !m_prf) m_prf = 1;
      if (ld_acc) begin m_pld = 1; m_lwe = p.lwe; m_ald = p.la; m_dld = p.ld; end
      prev_rd = p.rd; prev_wr = p.wr; prev_rf = p.rf;
      if (g != OP_NONE) begin
        win_on  = 1;
        win_op  = g;
        win_end = cyc + ((g == OP_RF) ? RFLEN : OPLEN);
      end
    end

    check("sdrRd", 32'(bus.sdrRd), 32'(g == OP_CRD || g == OP_LRD));
    check("sdrWr", 32'(bus.sdrWr), 32'(g == OP_CWR || g == OP_LWR));
    check("sdrRf", 32'(bus.sdrRf), 32'(g == OP_RF));
    if (!p.rst) begin
      check("rst_sdrA", 32'(bus.sdrA), 32'd0);
      check("rst_sdrD", 32'(bus.sdrD), 32'd0);
      check("rst_ldrQ", 32'(bus.ldrQ), 32'd0);
    end
    if (win_on && win_op != OP_RF)
      check("sdrA", 32'(bus.sdrA), 32'(win_a));
    if (win_on && (win_op == OP_CWR || win_op == OP_LWR))
      check("sdrD", 32'(bus.sdrD), 32'({2{win_d}}));
    check("cpuQ", 32'(bus.cpuQ), 32'(m_cpuq));
    check("ldrAck", 32'(bus.ldrAck), 32'(m_ack));
    check("ldrBusy", 32'(bus.ldrBusy), 32'(m_pld));
    if (m_ack) check("ldrQ", 32'(bus.ldrQ), 32'(m_ldrq));
`ifdef SDRAM_ARBITER_WAIT_EN
    check("cpuWait", 32'(bus.cpuWait),
          32'(m_prd || m_pwr || (win_on && (win_op == OP_CRD || win_op == OP_CWR))));
`endif

    p.rst  = reset;
    p.rd   = bus.cpuRd;  p.wr  = bus.cpuWr; p.rf = bus.cpuRf;
    p.a    = bus.cpuA;   p.d   = bus.cpuD;
    p.lreq = bus.ldrReq; p.lwe = bus.ldrWe; p.la = bus.ldrA; p.ld = bus.ldrD;
    p.q    = bus.sdrQ;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpuRd = 0; bus.cpuWr = 0; bus.cpuRf = 0; bus.ldrReq = 0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (60) step();
  endtask

  int n, s, acks, ack_at, wr1, wr2, last_strobe;
  int codes[$];
  int at[$];

  initial begin
    idle_inputs();
    bus.cpuA = '0; bus.cpuD = '0; bus.ldrWe = 0; bus.ldrA = '0; bus.ldrD = '0;
    bus.sdrQ = '0;
    repeat (3) step();
    reset = 1;

    // Random phase
    repeat (3000) begin
      step();
      if ($urandom_range(15) == 0) bus.cpuRd = ~bus.cpuRd;
      if ($urandom_range(15) == 0) bus.cpuWr = ~bus.cpuWr;
      if ($urandom_range(19) == 0) bus.cpuRf = ~bus.cpuRf;
      bus.cpuA   = AW'($urandom);
      bus.cpuD   = 8'($urandom);
      bus.ldrReq = ($urandom_range(9) == 0);
      bus.ldrWe  = 1'($urandom);
      bus.ldrA   = AW'($urandom);
      bus.ldrD   = 8'($urandom);
      bus.sdrQ   = 16'($urandom);
      reset      = ($urandom_range(399) != 0);
    end
    reset = 1;

    // Reset held with requests active, then first read latency
    reset = 0; bus.cpuRd = 1; bus.cpuRf = 1; bus.ldrReq = 1;
    repeat (4) step();
    check("rst_hold_sdrRd", 32'(bus.sdrRd), 32'd0);
    check("rst_hold_busy", 32'(bus.ldrBusy), 32'd0);
    check("rst_hold_cpuQ", 32'(bus.cpuQ), 32'd0);
    idle_inputs();
    step(); reset = 1; step(); step();
    bus.cpuRd = 1; n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.sdrRd) begin n = i; break; end
    end
    check("rst_first_rd_latency", 32'(n), 32'd2);

    // CPU read at 18'h04000 returning A5
    drain();
    bus.cpuA = 18'h04000; bus.sdrQ = 16'h00A5; bus.cpuRd = 1; n = 0;
    repeat (20) begin
      step();
      if (bus.sdrRd) begin
        n++;
        check("cpu_rd_sdrA", 32'(bus.sdrA), 32'h004000);
      end
    end
    check("cpu_rd_pulses", 32'(n), 32'd1);
    check("cpu_rd_cpuQ", 32'(bus.cpuQ), 32'hA5);

    // Loader write, then CPU write edge two clocks later
    drain();
    bus.ldrReq = 1; bus.ldrWe = 1; bus.ldrA = 18'h00100; bus.ldrD = 8'h3C;
    bus.cpuA = 18'h00200; bus.cpuD = 8'h77;
    ack_at = -1; wr1 = -1; wr2 = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      bus.ldrReq = 0;
      if (bus.sdrWr) begin
        if (wr1 < 0) begin
          wr1 = i;
          check("ldr_wr_sdrD", 32'(bus.sdrD), 32'h3C3C);
        end else if (wr2 < 0) begin
          wr2 = i;
        end
      end
      if (bus.ldrAck) ack_at = i;
      if (i == 2) bus.cpuWr = 1;
    end
    check("ldr_wr_first_strobe", 32'(wr1), 32'd2);
    check("ldr_wr_ack_seen", 32'(ack_at > 0), 32'd1);
    check("cpu_wr_after_ack", 32'(wr2 - ack_at), 32'd1);

    // Simultaneous refresh, CPU read and loader write
    drain();
    bus.cpuRf = 1; bus.cpuRd = 1; bus.ldrReq = 1; bus.ldrWe = 1;
    codes.delete(); at.delete(); ack_at = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      bus.ldrReq = 0;
      if (bus.sdrRd || bus.sdrWr || bus.sdrRf) begin
        codes.push_back({29'd0, bus.sdrRf, bus.sdrWr, bus.sdrRd});
        at.push_back(i);
      end
      if (bus.ldrAck) ack_at = i;
    end
    check("order_count", 32'(codes.size()), 32'd3);
    if (codes.size() == 3) begin
      check("order_first_cpu", 32'(codes[0]), 32'd1);
      check("order_second_rf", 32'(codes[1]), 32'd4);
      check("order_third_ldr", 32'(codes[2]), 32'd2);
      last_strobe = at[2];
      check("order_ack_last", 32'(ack_at > last_strobe), 32'd1);
    end

    // Reset in the middle of a loader read
    drain();
    bus.ldrReq = 1; bus.ldrWe = 0; s = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      bus.ldrReq = 0;
      if (bus.sdrRd) begin s = i; break; end
    end
    check("midrst_ldr_started", 32'(s), 32'd2);
    repeat (3) step();
    reset = 0; step(); reset = 1;
    check("midrst_busy_cleared", 32'(bus.ldrBusy), 32'd0);
    acks = 0;
    repeat (15) begin
      step();
      if (bus.ldrAck) acks++;
    end
    check("midrst_no_ack", 32'(acks), 32'd0);
    bus.ldrReq = 1; step(); bus.ldrReq = 0;
    check("midrst_new_accept", 32'(bus.ldrBusy), 32'd1);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.ldrAck) begin acks = 1; break; end
    end
    check("midrst_new_ack", 32'(acks), 32'd1);

`ifdef SDRAM_ARBITER_WAIT_EN
    // cpuWait spans the loader remainder, one idle clock and the CPU window
    drain();
    bus.ldrReq = 1; bus.ldrWe = 0;
    step(); bus.ldrReq = 0;
    step();
    bus.cpuRd = 1; n = 0;
    step();
    check("wait_rises", 32'(bus.cpuWait), 32'd1);
    for (int i = 2; i <= 40; i++) begin
      step();
      if (!bus.cpuWait) begin n = i; break; end
    end
    check("wait_len", 32'(n), 32'd17);
`endif

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
